cond_logic: RTL and testbench
=============================

COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 Cond  input  4  instruction condition field, bits [31:28].
REQ-004 ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
REQ-005 FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V.
REQ-006 PCS  input  1  decoder request to write PC.
REQ-007 RegW  input  1  decoder request to write register file.
REQ-008 MemW  input  1  decoder request to write memory.
REQ-009 NoWrite  input  1  compare-type op; suppresses RegWrite only.
REQ-010 Stall  input  1  hold: no state change, no side effects this cycle.
REQ-011 Flush  input  1  kill current instruction: no side effects, no flag write.
REQ-012 PCSrc  output  1  gated PC write.
REQ-013 RegWrite  output  1  gated register write.
REQ-014 MemWrite  output  1  gated memory write.
REQ-015 CondEx  output  1  combinational condition result for current Cond.
REQ-016 CondExQ  output  1  CondEx registered, for multi-cycle sequencing.
REQ-017 Flags  output  4  architectural {N,Z,C,V} register contents.

Function
REQ-018 Condition SHALL be evaluated against the registered Flags, never ALUFlags of the same cycle.
REQ-019 Cond decode: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V.
REQ-020 Cond decode: 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 1.
REQ-021 Define Go = CondEx & ~Stall & ~Flush.
REQ-022 PCSrc = PCS & Go; MemWrite = MemW & Go; RegWrite = RegW & ~NoWrite & Go; all combinational, zero latency.
REQ-023 On rising edge with Go=1: Flags[3:2] <= ALUFlags[3:2] if FlagW[1]; Flags[1:0] <= ALUFlags[1:0] if FlagW[0].
REQ-024 Flag halves SHALL update independently; FlagW=10 leaves C,V unchanged; FlagW=01 leaves N,Z unchanged.
REQ-025 Go=0 (condition fail, Stall or Flush) SHALL leave Flags unchanged regardless of FlagW.
REQ-026 CondExQ <= CondEx & ~Flush each edge when Stall=0; held when Stall=1.
REQ-027 Stall and Flush both high: Flush wins for outputs (all 0), Stall wins for CondExQ (held).
REQ-028 Updated Flags SHALL be visible to CondEx exactly one cycle after the writing edge.
REQ-029 Back-to-back flag-setting instructions SHALL each see the previous one's result (one-cycle latency, no bypass).

Reset
REQ-030 reset_n low SHALL immediately force Flags=0000 and CondExQ=0, independent of clk.
REQ-031 During reset PCSrc, RegWrite, MemWrite SHALL be 0.
REQ-032 Reset asserted mid-instruction SHALL discard any pending flag write; first edge after release performs normal operation.
REQ-033 After reset, Cond=0000 (EQ) SHALL evaluate false (Z=0); Cond=1110 true.

Verification
REQ-034 Reset, Cond=1110, RegW=1, FlagW=11, ALUFlags=0100 -> RegWrite=1 same cycle; next cycle Flags=0100.
REQ-035 Flags=0100, Cond=0001 (NE), MemW=1, FlagW=11, ALUFlags=1010 -> MemWrite=0, Flags stay 0100.
REQ-036 Flags=0000, FlagW=10, ALUFlags=1111 -> Flags=1100; then FlagW=01, ALUFlags=0011 -> Flags=1111.
REQ-037 Sweep all 16 Cond codes against all 16 Flags values -> CondEx matches REQ-019/020 table, 256 checks.
REQ-038 Cond=1110, PCS=1, FlagW=11, Stall=1 -> PCSrc=0, Flags and CondExQ unchanged; Stall=0 next -> PCSrc=1, flags written.
REQ-039 Flags=1010, reset_n pulsed low between edges -> Flags=0000 before next edge; Flush=1 with RegW=1 -> RegWrite=0, CondExQ=0.

Source files
------------

// File: rtl/cond_logic.sv
// cond_logic: condition-check and flag-register unit.
// Evaluates the instruction condition against the architectural flags and
// gates the PC, register-file and memory write requests. It also holds the
// {N,Z,C,V} flag register and a registered copy of the condition result.
module cond_logic (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  input  logic       Flush,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       CondExQ,
  output logic [3:0] Flags
);

  logic n, z, c, v;
  logic go;

  assign {n, z, c, v} = Flags;

  // Decode the condition field against the registered flags only
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      4'b1110: CondEx = 1'b1;
      4'b1111: CondEx = 1'b1;
    endcase
  end

  // reset_n is folded in so side effects stay low while reset is held
  assign go       = CondEx & ~Stall & ~Flush & reset_n;
  assign PCSrc    = PCS & go;
  assign MemWrite = MemW & go;
  assign RegWrite = RegW & ~NoWrite & go;

  // Flag register: N,Z and C,V halves written independently when the instruction goes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Flags <= '0;
    end else if (go) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Registered condition result; Stall holds it, Flush clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      CondExQ <= 1'b0;
    end else if (!Stall) begin
      CondExQ <= CondEx & ~Flush;
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: scoreboard bench for cond_logic.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, Stall, Flush;
  logic       PCSrc, RegWrite, MemWrite, CondEx, CondExQ;
  logic [3:0] Flags;

  cond_logic dut (
    .clk(clk), .reset_n(reset_n), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .CondEx(CondEx), .CondExQ(CondExQ), .Flags(Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pcsrc, regwrite, memwrite, condex, condexq;
    logic [3:0] flags;
  } exp_t;

  exp_t sb[$];
  logic [3:0] mflags;
  logic       mq;
  int unsigned nvec = 0;
  int unsigned nmis = 0;

  // Reference condition: pairs of codes share a base test, odd code inverts it
  function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cc[3:1] == 3'd7) ? 1'b1 : (base ^ cc[0]);
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cc, input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw,
                       input logic nw, input logic st, input logic fl);
    Cond = cc; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = regw;
    MemW = memw; NoWrite = nw; Stall = st; Flush = fl;
  endtask

  task automatic expect_now();
    exp_t e;
    logic ce, go;
    ce = model_cond(Cond, mflags);
    go = ce & ~Stall & ~Flush & reset_n;
    e.pcsrc    = PCS & go;
    e.regwrite = RegW & ~NoWrite & go;
    e.memwrite = MemW & go;
    e.condex   = ce;
    e.condexq  = mq;
    e.flags    = mflags;
    sb.push_back(e);
  endtask

  task automatic compare_now(input string tag);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 4'd1, 4'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "/PCSrc"},    {3'b0, PCSrc},    {3'b0, e.pcsrc});
      chk({tag, "/RegWrite"}, {3'b0, RegWrite}, {3'b0, e.regwrite});
      chk({tag, "/MemWrite"}, {3'b0, MemWrite}, {3'b0, e.memwrite});
      chk({tag, "/CondEx"},   {3'b0, CondEx},   {3'b0, e.condex});
      chk({tag, "/CondExQ"},  {3'b0, CondExQ},  {3'b0, e.condexq});
      chk({tag, "/Flags"},    Flags,            e.flags);
    end
  endtask

  task automatic observe(input string tag);
    expect_now();
    compare_now(tag);
  endtask

  // Advance one clock edge, updating the model from the inputs held across it
  task automatic tick();
    logic ce, go;
    logic [3:0] nf;
    logic nq;
    ce = model_cond(Cond, mflags);
    go = ce & ~Stall & ~Flush & reset_n;
    nf = mflags;
    nq = mq;
    if (!reset_n) begin
      nf = '0;
      nq = 1'b0;
    end else begin
      if (go && FlagW[1]) nf[3:2] = ALUFlags[3:2];
      if (go && FlagW[0]) nf[1:0] = ALUFlags[1:0];
      if (!Stall) nq = ce & ~Flush;
    end
    @(posedge clk);
    mflags = nf;
    mq = nq;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    mflags = '0;
    mq = 1'b0;
    drive(4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0);
    #2 observe("rst_gate");
    chk("rst_regw", {3'b0, RegWrite}, 4'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    drive(4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
    observe("eq_after_rst");
    chk("eq_after_rst_k", {3'b0, CondEx}, 4'd0);
    drive(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
    observe("al_after_rst");

    drive(4'b1110, 4'b0100, 2'b11, 0, 1, 0, 0, 0, 0);
    observe("al_write");
    chk("al_write_regw", {3'b0, RegWrite}, 4'd1);
    tick();
    observe("al_flags");
    chk("al_flags_k", Flags, 4'b0100);

    drive(4'b0001, 4'b1010, 2'b11, 0, 0, 1, 0, 0, 0);
    observe("ne_fail");
    chk("ne_fail_memw", {3'b0, MemWrite}, 4'd0);
    tick();
    chk("ne_fail_flags", Flags, 4'b0100);

    drive(4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0, 0);
    tick();
    drive(4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0, 0, 0);
    tick();
    observe("half_nz");
    chk("half_nz_k", Flags, 4'b1100);
    drive(4'b1110, 4'b0011, 2'b01, 0, 0, 0, 0, 0, 0);
    tick();
    observe("half_cv");
    chk("half_cv_k", Flags, 4'b1111);

    drive(4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    drive(4'b1110, 4'b0110, 2'b11, 1, 0, 0, 0, 1, 0);
    observe("stall");
    tick();
    observe("stall_held");
    chk("stall_q_k", {3'b0, CondExQ}, 4'd0);
    drive(4'b1110, 4'b0110, 2'b11, 1, 0, 0, 0, 0, 0);
    observe("unstall");
    chk("unstall_pcsrc", {3'b0, PCSrc}, 4'd1);
    tick();
    observe("unstall_flags");
    chk("unstall_flags_k", Flags, 4'b0110);

    drive(4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0);
    tick();
    drive(4'b0000, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 0);
    observe("b2b_eq_true");
    tick();
    drive(4'b0000, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0);
    observe("b2b_eq_false");
    tick();
    chk("b2b_flags", Flags, 4'b1000);

    for (int f = 0; f < 16; f++) begin
      drive(4'b1110, 4'(f), 2'b11, 0, 0, 0, 0, 0, 0);
      tick();
      drive(4'b1110, 4'(f), 2'b00, 1, 1, 1, 0, 1, 0);
      for (int cc = 0; cc < 16; cc++) begin
        Cond = 4'(cc);
        observe($sformatf("sweep_f%0h_c%0h", f, cc));
      end
      @(posedge clk);
      #1;
    end

    drive(4'b1110, 4'b1010, 2'b11, 0, 0, 0, 0, 0, 0);
    tick();
    drive(4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    mflags = '0;
    mq = 1'b0;
    observe("async_rst");
    chk("async_rst_k", Flags, 4'b0000);
    #1 reset_n = 1'b1;
    tick();
    observe("post_rst_edge");
    chk("post_rst_edge_k", Flags, 4'b1111);

    drive(4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0, 0, 1);
    observe("flush");
    chk("flush_regw", {3'b0, RegWrite}, 4'd0);
    tick();
    observe("flush_after");
    chk("flush_q", {3'b0, CondExQ}, 4'd0);

    drive(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    drive(4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0, 1, 1);
    observe("stall_flush");
    tick();
    observe("stall_flush_after");
    chk("stall_flush_q", {3'b0, CondExQ}, 4'd1);

    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0));
      observe($sformatf("rand%0d", i));
      tick();
    end
    observe("final");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
